// File: rtl/sum_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one CHUNK-bit slice.
// Start/Busy/Done handshake; results held until the next completion.
module sum_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [WIDTH-1:0]       acc;
  logic                   carry;
  logic [CW-1:0]          cnt;
  logic                   a_msb;
  logic                   b_msb;
  logic                   last;
  logic                   accept;
  logic [CHUNK:0]         sum_ext;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_n;
  logic                   ovf_n;

  // One CHUNK-wide slice plus the shifted partial result
  always_comb begin
    sum_ext = {1'b0, op_a[CHUNK-1:0]}
            + {1'b0, op_b[CHUNK-1:0]}
            + {{CHUNK{1'b0}}, carry};
    acc_cat = {sum_ext[CHUNK-1:0], acc};
    acc_n   = acc_cat[WIDTH+CHUNK-1:CHUNK];
    ovf_n   = (a_msb == b_msb) && (acc_n[WIDTH-1] != a_msb);
    last    = (cnt == CW'(N - 1));
    accept  = (state == IDLE) && Start;
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and busy flag
  always_comb begin
    state_n = state;
    Busy    = 1'b0;
    unique case (state)
      IDLE: if (Start) state_n = RUN;
      RUN: begin
        Busy = 1'b1;
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, chunk iteration and result registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= (state == RUN) && last;
      if (accept) begin
        op_a  <= A;
        op_b  <= Sub ? ~B : B;
        carry <= Cin ^ Sub;
        cnt   <= '0;
        acc   <= '0;
        a_msb <= A[WIDTH-1];
        b_msb <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
      end else if (state == RUN) begin
        op_a  <= op_a >> CHUNK;
        op_b  <= op_b >> CHUNK;
        carry <= sum_ext[CHUNK];
        acc   <= acc_n;
        cnt   <= cnt + CW'(1);
        if (last) begin
          S    <= acc_n;
          Cout <= sum_ext[CHUNK];
          Ovf  <= ovf_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_serial.sv
// Bench for sum_serial: CHUNK=1 and CHUNK=4 instances, 8-bit.
// Integer-arithmetic reference model, directed plus random steps.
module tb_sum_serial;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       Sub;
  logic       start1;
  logic       start4;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] s1, s4;

  int compared;
  int mismatched;

  sum_serial #(.WIDTH(8), .CHUNK(1)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start1),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Busy(busy1), .Done(done1), .S(s1),
    .Cout(cout1), .Ovf(ovf1)
  );

  sum_serial #(.WIDTH(8), .CHUNK(4)) u_dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(start4),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Busy(busy4), .Done(done4), .S(s4),
    .Cout(cout4), .Ovf(ovf4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, s} from signed/unsigned integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic cin,
                                       input logic sub);
    int ua, ub, u, sa, sb, r;
    logic [7:0] s;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub - int'(cin);
      r = sa - sb - int'(cin);
      c = (u >= 0);
    end else begin
      u = ua + ub + int'(cin);
      r = sa + sb + int'(cin);
      c = (u > 255);
    end
    s = u[7:0];
    o = (r > 127) || (r < -128);
    return {o, c, s};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input bit w4, input logic [7:0] a,
                     input logic [7:0] b, input logic cin,
                     input logic sub, input string tag);
    int n, busy_cnt, done_edge;
    logic [9:0] m;
    n = w4 ? 2 : 8;
    m = model(a, b, cin, sub);
    A = a; B = b; Cin = cin; Sub = sub;
    if (w4) start4 = 1'b1;
    else    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    start4 = 1'b0;
    A = $urandom; B = $urandom;
    Cin = $urandom; Sub = $urandom;
    busy_cnt  = 0;
    done_edge = 0;
    for (int e = 1; e <= n + 2 && done_edge == 0; e++) begin
      if (w4 ? busy4 : busy1) busy_cnt++;
      tick();
      if (w4 ? done4 : done1) done_edge = e;
    end
    chk({tag, "_done_edge"}, done_edge, n);
    chk({tag, "_busy_cycles"}, busy_cnt, n);
    chk({tag, "_busy_low"}, w4 ? busy4 : busy1, 1'b0);
    chk({tag, "_s"}, w4 ? s4 : s1, m[7:0]);
    chk({tag, "_cout"}, w4 ? cout4 : cout1, m[8]);
    chk({tag, "_ovf"}, w4 ? ovf4 : ovf1, m[9]);
    tick();
    chk({tag, "_done_drop"}, w4 ? done4 : done1, 1'b0);
  endtask

  initial begin
    int dcnt, dedge;
    logic [9:0] m;
    compared   = 0;
    mismatched = 0;
    Rst_n  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #12;
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_s1", s1, 8'h00);
    chk("rst_cout1", cout1, 1'b0);
    chk("rst_ovf1", ovf1, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_s4", s4, 8'h00);
    Rst_n = 1'b1;
    tick();

    run(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
    chk("lit_5a_3c_s", s1, 8'h96);
    chk("lit_5a_3c_ovf", ovf1, 1'b1);
    run(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, "add_ff_01");
    chk("lit_ff_01_s", s1, 8'h01);
    chk("lit_ff_01_cout", cout1, 1'b1);
    run(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20");
    chk("lit_10_20_s", s1, 8'hF0);
    run(1'b0, 8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    chk("lit_80_01_s", s1, 8'h7F);

    // Start re-pulsed at edge 3 must be ignored
    m = model(8'h5A, 8'h3C, 1'b0, 1'b0);
    A = 8'h5A; B = 8'h3C; Cin = 1'b0; Sub = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dcnt  = 0;
    dedge = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) begin
        A = 8'hFF; B = 8'hFF; Cin = 1'b1; Sub = 1'b1;
        start1 = 1'b1;
      end
      tick();
      if (e == 3) start1 = 1'b0;
      if (done1) begin
        dcnt++;
        if (dedge == 0) dedge = e;
      end
    end
    chk("ign_done_count", dcnt, 1);
    chk("ign_done_edge", dedge, 8);
    chk("ign_s", s1, m[7:0]);
    chk("ign_cout", cout1, m[8]);

    // Asynchronous reset mid-run
    A = 8'h80; B = 8'h01; Cin = 1'b0; Sub = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 1'b0);
    chk("arst_s", s1, 8'h00);
    chk("arst_cout", cout1, 1'b0);
    chk("arst_ovf", ovf1, 1'b0);
    tick();
    #2;
    Rst_n = 1'b1;
    dcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (done1) dcnt++;
    end
    chk("arst_no_done", dcnt, 0);
    run(1'b0, 8'h33, 8'h44, 1'b1, 1'b0, "post_rst");

    // CHUNK=4: overflow case, then back-to-back start in Done cycle
    A = 8'h7F; B = 8'h01; Cin = 1'b0; Sub = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    chk("c4_e1_done", done4, 1'b0);
    tick();
    chk("c4_e2_done", done4, 1'b1);
    chk("c4_e2_s", s4, 8'h80);
    chk("c4_e2_ovf", ovf4, 1'b1);
    A = 8'h03; B = 8'h02; Cin = 1'b0; Sub = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("c4_e3_busy", busy4, 1'b1);
    chk("c4_e3_s_hold", s4, 8'h80);
    tick();
    chk("c4_e4_s_hold", s4, 8'h80);
    chk("c4_e4_done", done4, 1'b0);
    tick();
    chk("c4_e5_done", done4, 1'b1);
    chk("c4_e5_s", s4, 8'h01);
    chk("c4_e5_cout", cout4, 1'b1);
    tick();

    // Randomized operations on both instances
    for (int i = 0; i < 25; i++) begin
      run(1'b0, 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), "rnd1");
    end
    for (int i = 0; i < 25; i++) begin
      run(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), "rnd4");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
